vga_frame_monitor: RTL
======================

# vga_frame_monitor

APB-readable monitor sitting directly downstream of the APB VGA controller in ysyxSoC. It consumes the controller's `vga_r/g/b`, `vga_hsync`, `vga_vsync` and `vga_valid` outputs. For each frame it reports the active-pixel count, the active-line count and a 32-bit additive pixel checksum. Software and testbenches use it to check framebuffer contents and timing without an external VGA model.

## Interface
Parameters:
- `H_ACTIVE`, default 640: expected active pixels per line.
- `V_ACTIVE`, default 480: expected active lines per frame.

Ports:
- `clock` in 1: single clock, shared with the VGA controller.
- `reset` in 1: synchronous, active-high.
- `in_paddr` in 32: APB address; only bits [4:2] are decoded.
- `in_psel`, `in_penable`, `in_pwrite` in 1 each: APB control.
- `in_pprot` in 3: ignored.
- `in_pwdata` in 32: APB write data.
- `in_pstrb` in 4: ignored; writes are always full-word.
- `in_pready` out 1: APB ready.
- `in_prdata` out 32: APB read data.
- `in_pslverr` out 1: APB error.
- `vga_r`, `vga_g`, `vga_b` in 8 each: pixel colour from the VGA controller.
- `vga_hsync`, `vga_vsync` in 1 each: syncs, low during the pulse. `vga_hsync` is ignored.
- `vga_valid` in 1: active-pixel qualifier.
- `irq` out 1: frame-done interrupt, level.

## Operation
Register map (byte offset):
- 0x00 CTRL, RW: bit0 `en`, bit1 `irq_en`; other bits read 0.
- 0x04 STATUS, R/W1C: bit0 `frame_done`, bit1 `geom_err`.
- 0x08 FRAME_CNT, RO: completed frames, 32-bit, wraps.
- 0x0C LAST_SUM, RO.
- 0x10 LAST_PIX, RO.
- 0x14 LAST_LINES, RO: 16-bit value, zero-extended.

Accumulators:
- `acc_sum` (32-bit, mod 2^32) adds `{8'h0,r,g,b}` on each cycle with `vga_valid`=1.
- `acc_pix` (32-bit) counts cycles with `vga_valid`=1.
- `acc_lines` (16-bit) counts falling edges of `vga_valid`.

Edge detection:
- Previous `vga_vsync` and `vga_valid` are held in registers, both reset to 1 and 0 respectively.
- `vs_fall` = prev_vsync & ~vga_vsync.
- `va_fall` = prev_valid & ~vga_valid.

FSM states:
- DISABLED: accumulators held at 0. `en`=1 moves to WAIT_SYNC.
- WAIT_SYNC: discards the partial frame. On `vs_fall`, load the accumulators with this cycle's contribution and go to CAPTURE. Results are not latched.
- CAPTURE: accumulate every cycle. On `vs_fall`:
  - Latch the pre-cycle accumulators into LAST_SUM, LAST_PIX and LAST_LINES.
  - FRAME_CNT += 1; set `frame_done`.
  - Set `geom_err` if latched pix ≠ H_ACTIVE·V_ACTIVE or latched lines ≠ V_ACTIVE.
  - Reload the accumulators with this cycle's contribution. Stay in CAPTURE.
- Any state with `en`=0 (written): go to DISABLED on the next cycle and zero the accumulators. LAST_* and FRAME_CNT are kept.

Other rules:
- This cycle's contribution: sum = valid ? pixel : 0, pix = valid, lines = `va_fall`.
- `irq` = `irq_en` & `frame_done`.
- W1C: writing 1 clears the bit. If a hardware set and a W1C hit the same cycle, the set wins.

## Timing
- Reset: all registers 0, state DISABLED; `in_pready`=0, `in_prdata`=0, `in_pslverr`=0, `irq`=0.
- APB is zero-wait: `in_pready` = `in_psel` & `in_penable`.
- Read data is combinational during the access phase and is 0 outside it.
- A write commits at the clock edge that ends the access phase. The CTRL write takes effect for the FSM from the next cycle.
- `in_pslverr` = access & (offset > 0x14 | write to 0x08–0x14). An erroring write has no effect.
- LAST_*, FRAME_CNT and `frame_done` update at the edge ending the `vs_fall` cycle. `irq` rises one cycle after `vs_fall`.
- A reset mid-frame discards everything. The first frame after re-enable is never reported.
- Accumulator overflow wraps silently.

## Test plan
Run with `H_ACTIVE`=4, `V_ACTIVE`=2.
- Reset: hold `reset` 2 cycles, then read all six registers -> all 0, `irq`=0.
- Clean frames: write CTRL=3. Drive 3 frames, each with 2 lines × 4 valid pixels of 0x000001..0x000008, and a `vsync` low pulse between frames -> after the 3rd `vs_fall`: FRAME_CNT=2, LAST_SUM=0x24, LAST_PIX=8, LAST_LINES=2, STATUS=1, `irq`=1.
- Geometry error: one frame with 3 pixels on line 2 -> LAST_PIX=7, STATUS bit1=1.
- W1C collision: write STATUS=1 in the same cycle as `vs_fall` -> `frame_done` stays 1. A later write of 3 -> STATUS=0, `irq`=0.
- Bus errors: read 0x18 and write 0x0C -> `in_pslverr`=1, and LAST_SUM is unchanged.
- Disable mid-frame: write CTRL=0 after 5 pixels, re-enable, run 2 full frames -> FRAME_CNT increments by 1 only, and LAST_PIX=8.

Source files
------------

// File: rtl/vga_frame_monitor_if.sv
// APB slave bundle for the VGA frame monitor; signal names match the ysyxSoC APB port naming.
interface vga_frame_monitor_if;
  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic        in_pwrite;
  logic [2:0]  in_pprot;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;

  modport master (
    output in_paddr, in_psel, in_penable, in_pwrite, in_pprot, in_pwdata, in_pstrb,
    input  in_pready, in_prdata, in_pslverr
  );

  modport slave (
    input  in_paddr, in_psel, in_penable, in_pwrite, in_pprot, in_pwdata, in_pstrb,
    output in_pready, in_prdata, in_pslverr
  );
endinterface

// File: rtl/vga_frame_monitor.sv
// Per-frame pixel count, line count and additive checksum of the VGA controller output,
// framed by vsync falling edges and exposed through a zero-wait APB register file.
module vga_frame_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic                 clock,
  input  logic                 reset,
  vga_frame_monitor_if.slave   apb,
  input  logic [7:0]           vga_r,
  input  logic [7:0]           vga_g,
  input  logic [7:0]           vga_b,
  input  logic                 vga_hsync,
  input  logic                 vga_vsync,
  input  logic                 vga_valid,
  output logic                 irq,
  output logic [1:0]           state_dbg
);

  localparam logic [1:0] ST_DISABLED  = 2'd0;
  localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
  localparam logic [1:0] ST_CAPTURE   = 2'd2;

  localparam logic [31:0] EXP_PIX   = 32'(H_ACTIVE * V_ACTIVE);
  localparam logic [15:0] EXP_LINES = 16'(V_ACTIVE);

  logic [1:0]  state;
  logic        en, irq_en;
  logic        frame_done, geom_err;
  logic [31:0] frame_cnt, last_sum, last_pix;
  logic [15:0] last_lines;
  logic [31:0] acc_sum, acc_pix;
  logic [15:0] acc_lines;
  logic        prev_vsync, prev_valid;

  // APB handshake: a transfer is the access phase (psel & penable); it always
  // completes in that cycle, reads are combinational, writes commit at its closing edge.
  logic       access;
  logic [2:0] idx;
  logic       bad_addr, slverr, wr_ok, ctrl_wr, status_wr;

  assign access    = apb.in_psel & apb.in_penable;
  assign idx       = apb.in_paddr[4:2];
  assign bad_addr  = idx > 3'd5;
  assign slverr    = access & (bad_addr | (apb.in_pwrite & (idx >= 3'd2)));
  assign wr_ok     = access & apb.in_pwrite & ~slverr;
  assign ctrl_wr   = wr_ok & (idx == 3'd0);
  assign status_wr = wr_ok & (idx == 3'd1);

  assign apb.in_pready  = access;
  assign apb.in_pslverr = slverr;

  always_comb begin
    apb.in_prdata = '0;
    if (access && !apb.in_pwrite) begin
      case (idx)
        3'd0:    apb.in_prdata = {30'b0, irq_en, en};
        3'd1:    apb.in_prdata = {30'b0, geom_err, frame_done};
        3'd2:    apb.in_prdata = frame_cnt;
        3'd3:    apb.in_prdata = last_sum;
        3'd4:    apb.in_prdata = last_pix;
        3'd5:    apb.in_prdata = {16'b0, last_lines};
        default: apb.in_prdata = '0;
      endcase
    end
  end

  logic        vs_fall, va_fall;
  logic [31:0] c_sum, c_pix;
  logic [15:0] c_lines;
  logic        latch, geom_set;

  assign vs_fall  = prev_vsync & ~vga_vsync;
  assign va_fall  = prev_valid & ~vga_valid;
  assign c_sum    = vga_valid ? {8'h0, vga_r, vga_g, vga_b} : 32'h0;
  assign c_pix    = {31'b0, vga_valid};
  assign c_lines  = {15'b0, va_fall};
  assign latch    = en & (state == ST_CAPTURE) & vs_fall;
  assign geom_set = latch & ((acc_pix != EXP_PIX) | (acc_lines != EXP_LINES));

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_DISABLED;
      en         <= 1'b0;
      irq_en     <= 1'b0;
      frame_done <= 1'b0;
      geom_err   <= 1'b0;
      frame_cnt  <= '0;
      last_sum   <= '0;
      last_pix   <= '0;
      last_lines <= '0;
      acc_sum    <= '0;
      acc_pix    <= '0;
      acc_lines  <= '0;
      prev_vsync <= 1'b1;
      prev_valid <= 1'b0;
    end else begin
      prev_vsync <= vga_vsync;
      prev_valid <= vga_valid;
      if (ctrl_wr) begin
        en     <= apb.in_pwdata[0];
        irq_en <= apb.in_pwdata[1];
      end
      // Hardware set is ORed in after the W1C clear so a same-cycle set survives.
      frame_done <= (frame_done & ~(status_wr & apb.in_pwdata[0])) | latch;
      geom_err   <= (geom_err   & ~(status_wr & apb.in_pwdata[1])) | geom_set;

      if (!en) begin
        state     <= ST_DISABLED;
        acc_sum   <= '0;
        acc_pix   <= '0;
        acc_lines <= '0;
      end else begin
        case (state)
          ST_DISABLED: begin
            state     <= ST_WAIT_SYNC;
            acc_sum   <= '0;
            acc_pix   <= '0;
            acc_lines <= '0;
          end
          ST_WAIT_SYNC: begin
            if (vs_fall) begin
              state     <= ST_CAPTURE;
              acc_sum   <= c_sum;
              acc_pix   <= c_pix;
              acc_lines <= c_lines;
            end
          end
          ST_CAPTURE: begin
            if (vs_fall) begin
              last_sum   <= acc_sum;
              last_pix   <= acc_pix;
              last_lines <= acc_lines;
              frame_cnt  <= frame_cnt + 32'd1;
              acc_sum    <= c_sum;
              acc_pix    <= c_pix;
              acc_lines  <= c_lines;
            end else begin
              acc_sum   <= acc_sum + c_sum;
              acc_pix   <= acc_pix + c_pix;
              acc_lines <= acc_lines + c_lines;
            end
          end
          default: state <= ST_DISABLED;
        endcase
      end
    end
  end

  assign irq       = irq_en & frame_done;
  assign state_dbg = state;

  logic unused_ok;
  assign unused_ok = ^{apb.in_pprot, apb.in_pstrb, apb.in_pwdata[31:2],
                       apb.in_paddr[31:5], apb.in_paddr[1:0], vga_hsync};

endmodule
